avalon_pio_debounce: RTL and testbench

//  Parametrised Avalon-MM PIO peripheral for the base system: debounced push-button inputs plus LED outputs.
//  Per-bit synchroniser and debouncer, edge capture with per-bit rising/falling enables, maskable level IRQ.

---
 rtl/avalon_pio_debounce_if.sv | 29 ++
 rtl/avalon_pio_debounce.sv | 182 ++++++++++++++++++
 tb/tb_avalon_pio_debounce.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_pio_debounce_if.sv
// Avalon-MM slave bus bundle for the debounced PIO peripheral.
// The bus master (Nios II data master or a testbench) drives address/strobes/data;
// the peripheral returns registered read data and its level interrupt.
interface avalon_pio_debounce_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/avalon_pio_debounce.sv
// Avalon-MM PIO peripheral: debounced push-button inputs with edge capture
// and a maskable level interrupt, plus an LED output register with atomic
// bitwise set/clear. Zero wait states, read latency of one clock.
module avalon_pio_debounce #(
    parameter int                   IN_WIDTH        = 2,
    parameter int                   OUT_WIDTH       = 8,
    parameter int                   DEBOUNCE_CYCLES = 50000,
    parameter logic [IN_WIDTH-1:0]  IN_RESET_VAL    = '1,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET_VAL   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    avalon_pio_debounce_if.slave   bus,
    input  logic [IN_WIDTH-1:0]    pio_in,
    output logic [OUT_WIDTH-1:0]   pio_out
);

    // Counter holds up to DEBOUNCE_CYCLES-1 before the accepting cycle.
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ADDR_DATA_IN  = 3'd0,
        ADDR_DATA_OUT = 3'd1,
        ADDR_OUT_SET  = 3'd2,
        ADDR_OUT_CLR  = 3'd3,
        ADDR_IRQ_MASK = 3'd4,
        ADDR_EDGE_CAP = 3'd5,
        ADDR_RISE_EN  = 3'd6,
        ADDR_FALL_EN  = 3'd7
    } reg_addr_e;

    logic [IN_WIDTH-1:0]  sync_meta;
    logic [IN_WIDTH-1:0]  sync_q;
    logic [IN_WIDTH-1:0]  debounced;
    logic [IN_WIDTH-1:0]  debounced_d;
    logic [CNT_W-1:0]     db_cnt [IN_WIDTH];

    logic [IN_WIDTH-1:0]  edge_cap;
    logic [IN_WIDTH-1:0]  irq_mask;
    logic [IN_WIDTH-1:0]  rise_en;
    logic [IN_WIDTH-1:0]  fall_en;

    logic [IN_WIDTH-1:0]  rise;
    logic [IN_WIDTH-1:0]  fall;
    logic [IN_WIDTH-1:0]  new_edges;
    logic [IN_WIDTH-1:0]  cap_clear;

    logic [IN_WIDTH-1:0]  wd_in;
    logic [OUT_WIDTH-1:0] wd_out;
    logic [31:0]          read_value;

    logic wr_out;
    logic wr_set;
    logic wr_clr;
    logic wr_mask;
    logic wr_cap;
    logic wr_rise;
    logic wr_fall;

    // Writedata bits above the register widths are architecturally ignored.
    logic unused_wd_bits;
    assign unused_wd_bits = ^bus.writedata;

    assign wd_in  = bus.writedata[IN_WIDTH-1:0];
    assign wd_out = bus.writedata[OUT_WIDTH-1:0];

    assign wr_out  = bus.write && (bus.address == ADDR_DATA_OUT);
    assign wr_set  = bus.write && (bus.address == ADDR_OUT_SET);
    assign wr_clr  = bus.write && (bus.address == ADDR_OUT_CLR);
    assign wr_mask = bus.write && (bus.address == ADDR_IRQ_MASK);
    assign wr_cap  = bus.write && (bus.address == ADDR_EDGE_CAP);
    assign wr_rise = bus.write && (bus.address == ADDR_RISE_EN);
    assign wr_fall = bus.write && (bus.address == ADDR_FALL_EN);

    assign rise      = debounced & ~debounced_d;
    assign fall      = ~debounced & debounced_d;
    assign new_edges = (rise & rise_en) | (fall & fall_en);
    assign cap_clear = wr_cap ? wd_in : '0;

    assign bus.irq = |(edge_cap & irq_mask);

    // Two-flop synchroniser bringing the raw button pins into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= IN_RESET_VAL;
            sync_q    <= IN_RESET_VAL;
        end else begin
            sync_meta <= pio_in;
            sync_q    <= sync_meta;
        end
    end

    // Per-bit debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debounced <= IN_RESET_VAL;
            for (int i = 0; i < IN_WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (sync_q[i] == debounced[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    debounced[i] <= sync_q[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed copy of the debounced level; reset to the same idle value so no edge appears at reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debounced_d <= IN_RESET_VAL;
        end else begin
            debounced_d <= debounced;
        end
    end

    // Sticky edge capture; a fresh edge on a bit beats a same-cycle write-one-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clear) | new_edges;
        end
    end

    // Interrupt mask and edge-direction enable registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
        end else begin
            if (wr_mask) irq_mask <= wd_in;
            if (wr_rise) rise_en  <= wd_in;
            if (wr_fall) fall_en  <= wd_in;
        end
    end

    // LED output register with plain write plus atomic bitwise set and clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pio_out <= OUT_RESET_VAL;
        end else if (wr_out) begin
            pio_out <= wd_out;
        end else if (wr_set) begin
            pio_out <= pio_out | wd_out;
        end else if (wr_clr) begin
            pio_out <= pio_out & ~wd_out;
        end
    end

    // Read mux over the current register state, so a simultaneous write is seen only by later reads.
    always_comb begin
        read_value = '0;
        case (bus.address)
            ADDR_DATA_IN:  read_value[IN_WIDTH-1:0]  = debounced;
            ADDR_DATA_OUT: read_value[OUT_WIDTH-1:0] = pio_out;
            ADDR_IRQ_MASK: read_value[IN_WIDTH-1:0]  = irq_mask;
            ADDR_EDGE_CAP: read_value[IN_WIDTH-1:0]  = edge_cap;
            ADDR_RISE_EN:  read_value[IN_WIDTH-1:0]  = rise_en;
            ADDR_FALL_EN:  read_value[IN_WIDTH-1:0]  = fall_en;
            default:       read_value = '0;
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
        end else if (bus.read) begin
            bus.readdata <= read_value;
        end
    end

endmodule

// File: tb/tb_avalon_pio_debounce.sv
// Testbench for avalon_pio_debounce (DEBOUNCE_CYCLES=4, IN_WIDTH=2, OUT_WIDTH=8).
// Register behaviour is driven from a vector table; debounce, edge capture,
// set-vs-clear collision and mid-count reset are hand-written sequences.
// Read expectations go into a scoreboard queue and are compared when readdata is valid.
module tb_avalon_pio_debounce;

    logic       clk;
    logic       reset;
    logic [1:0] pio_in;
    logic [7:0] pio_out;

    avalon_pio_debounce_if bus();

    avalon_pio_debounce #(
        .IN_WIDTH        (2),
        .OUT_WIDTH       (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pio_in  (pio_in),
        .pio_out (pio_out)
    );

    typedef struct packed {
        logic [2:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    localparam int NUM_VECS = 21;

    vec_t        vecs [NUM_VECS];
    logic [31:0] exp_q [$];
    int          tag_q [$];
    int          rd_tag;
    logic        rd_pending;
    int          n_checks;
    int          n_fail;

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one bus cycle starting at a negedge; reads queue their expected data.
    task automatic applyStimulus(input logic [2:0] addr, input logic rd, input logic wr,
                                 input logic [31:0] wd, input logic [31:0] exp_rd);
        bus.address   = addr;
        bus.read      = rd;
        bus.write     = wr;
        bus.writedata = wd;
        if (rd) begin
            exp_q.push_back(exp_rd);
            tag_q.push_back(rd_tag);
            rd_tag++;
        end
        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
    endtask

    // Remember whether the DUT accepted a read on this edge.
    always @(posedge clk) begin
        rd_pending <= bus.read && !reset;
    end

    // Scoreboard: readdata is valid half a cycle after the edge that captured the read.
    always @(negedge clk) begin
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                checkOutput("scoreboard_underflow", 32'h1, 32'h0);
            end else begin
                checkOutput($sformatf("read%0d", tag_q.pop_front()), bus.readdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rd_tag        = 0;
        rd_pending    = 1'b0;
        reset         = 1'b1;
        pio_in        = 2'b11;
        bus.address   = 3'd0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = 32'h0;

        //          addr  rd    wr    wdata          exp_rd        exp_out
        vecs[0]  = '{3'd1, 1'b0, 1'b1, 32'h0000_00A5, 32'h0,        8'hA5};
        vecs[1]  = '{3'd2, 1'b0, 1'b1, 32'h0000_000F, 32'h0,        8'hAF};
        vecs[2]  = '{3'd3, 1'b0, 1'b1, 32'h0000_0081, 32'h0,        8'h2E};
        vecs[3]  = '{3'd1, 1'b1, 1'b0, 32'h0,         32'h0000_002E, 8'h2E};
        vecs[4]  = '{3'd2, 1'b1, 1'b0, 32'h0,         32'h0,        8'h2E};
        vecs[5]  = '{3'd3, 1'b1, 1'b0, 32'h0,         32'h0,        8'h2E};
        vecs[6]  = '{3'd1, 1'b1, 1'b1, 32'h0000_0055, 32'h0000_002E, 8'h55};
        vecs[7]  = '{3'd1, 1'b1, 1'b0, 32'h0,         32'h0000_0055, 8'h55};
        vecs[8]  = '{3'd1, 1'b0, 1'b1, 32'hFFFF_FF00, 32'h0,        8'h00};
        vecs[9]  = '{3'd0, 1'b0, 1'b1, 32'h0,         32'h0,        8'h00};
        vecs[10] = '{3'd0, 1'b1, 1'b0, 32'h0,         32'h0000_0003, 8'h00};
        vecs[11] = '{3'd4, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0,        8'h00};
        vecs[12] = '{3'd4, 1'b1, 1'b0, 32'h0,         32'h0000_0003, 8'h00};
        vecs[13] = '{3'd4, 1'b0, 1'b1, 32'h0,         32'h0,        8'h00};
        vecs[14] = '{3'd6, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,        8'h00};
        vecs[15] = '{3'd6, 1'b1, 1'b0, 32'h0,         32'h0,        8'h00};
        vecs[16] = '{3'd7, 1'b0, 1'b1, 32'h0000_0005, 32'h0,        8'h00};
        vecs[17] = '{3'd7, 1'b1, 1'b0, 32'h0,         32'h0000_0001, 8'h00};
        vecs[18] = '{3'd7, 1'b0, 1'b1, 32'h0,         32'h0,        8'h00};
        vecs[19] = '{3'd5, 1'b1, 1'b0, 32'h0,         32'h0,        8'h00};
        vecs[20] = '{3'd4, 1'b1, 1'b0, 32'h0,         32'h0,        8'h00};

        $display("[TB] start");

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_pio_out", {24'h0, pio_out}, 32'h0);
        checkOutput("reset_irq", {31'h0, bus.irq}, 32'h0);
        checkOutput("reset_readdata", bus.readdata, 32'h0);
        reset = 1'b0;
        applyStimulus(3'd0, 1'b1, 1'b0, 32'h0, 32'h3);
        applyStimulus(3'd5, 1'b1, 1'b0, 32'h0, 32'h0);

        // Register map vectors.
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d_pio_out", i), {24'h0, pio_out}, {24'h0, vecs[i].exp_out});
            checkOutput($sformatf("vec%0d_irq", i), {31'h0, bus.irq}, 32'h0);
        end

        // Debounce latency: DATA_IN flips at the 6th edge, seen on readdata at the 7th.
        pio_in = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(3'd0, 1'b1, 1'b0, 32'h0, (k < 7) ? 32'h3 : 32'h2);
        end

        // Three-cycle glitch is rejected.
        pio_in[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) pio_in[0] = 1'b0;
            applyStimulus(3'd0, 1'b1, 1'b0, 32'h0, 32'h2);
        end

        // Falling-edge capture on bit0 raises irq; W1C clears it.
        pio_in = 2'b11;
        idleCycles(8);
        applyStimulus(3'd7, 1'b0, 1'b1, 32'h1, 32'h0);
        applyStimulus(3'd4, 1'b0, 1'b1, 32'h1, 32'h0);
        checkOutput("irq_before_press", {31'h0, bus.irq}, 32'h0);
        pio_in = 2'b10;
        idleCycles(8);
        checkOutput("irq_after_press", {31'h0, bus.irq}, 32'h1);
        applyStimulus(3'd5, 1'b1, 1'b0, 32'h0, 32'h1);
        applyStimulus(3'd5, 1'b0, 1'b1, 32'h1, 32'h0);
        checkOutput("irq_after_w1c", {31'h0, bus.irq}, 32'h0);
        applyStimulus(3'd5, 1'b1, 1'b0, 32'h0, 32'h0);

        // New rising edge on bit1 in the same cycle as its W1C: set wins.
        applyStimulus(3'd7, 1'b0, 1'b1, 32'h3, 32'h0);
        applyStimulus(3'd6, 1'b0, 1'b1, 32'h2, 32'h0);
        applyStimulus(3'd4, 1'b0, 1'b1, 32'h2, 32'h0);
        pio_in = 2'b00;
        idleCycles(8);
        checkOutput("irq_bit1_fall", {31'h0, bus.irq}, 32'h1);
        applyStimulus(3'd5, 1'b1, 1'b0, 32'h0, 32'h2);
        pio_in = 2'b10;
        idleCycles(6);
        applyStimulus(3'd5, 1'b0, 1'b1, 32'h2, 32'h0);
        checkOutput("irq_set_wins", {31'h0, bus.irq}, 32'h1);
        applyStimulus(3'd5, 1'b1, 1'b0, 32'h0, 32'h2);
        applyStimulus(3'd5, 1'b0, 1'b1, 32'h2, 32'h0);
        checkOutput("irq_after_second_w1c", {31'h0, bus.irq}, 32'h0);
        applyStimulus(3'd5, 1'b1, 1'b0, 32'h0, 32'h0);

        // Reset in the middle of a debounce count with LEDs lit and irq pending.
        pio_in = 2'b00;
        idleCycles(8);
        checkOutput("irq_pre_reset", {31'h0, bus.irq}, 32'h1);
        applyStimulus(3'd1, 1'b0, 1'b1, 32'hFF, 32'h0);
        checkOutput("pio_out_pre_reset", {24'h0, pio_out}, 32'hFF);
        pio_in = 2'b01;
        idleCycles(4);
        reset = 1'b1;
        #1;
        checkOutput("midreset_pio_out", {24'h0, pio_out}, 32'h0);
        checkOutput("midreset_irq", {31'h0, bus.irq}, 32'h0);
        checkOutput("midreset_readdata", bus.readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(3'd0, 1'b1, 1'b0, 32'h0, 32'h3);
        applyStimulus(3'd5, 1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(3'd1, 1'b1, 1'b0, 32'h0, 32'h0);
        idleCycles(2);

        checkOutput("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
